bus_arbiter_n: RTL and testbench
================================

// Module: bus_arbiter_n
// PURPOSE
//  Parametrised N-client bus arbiter; successor to the fixed 4-client bus_arbiter.
//  Sits between NUM_CLIENTS client masters and one server (ram) on a rq/ack bus.
//  Selectable strict-priority or round-robin scheduling; optional ack-timeout watchdog.
//  Client buses are flattened vectors; client i occupies slice [i*W +: W].
// PARAMETERS
//  DATA_WIDTH   8      data bus width
//  ADDR_WIDTH   4      address bus width
//  NUM_CLIENTS  4      number of clients, 2..16
//  PW           2      priority field width per client, $clog2(NUM_CLIENTS)
//  PRIO_VEC     8'hE4  client i priority = PRIO_VEC[i*PW +: PW]; lower value wins
//  RR_MODE      0      0 = strict priority, 1 = round robin
//  TIMEOUT      16     BUSY cycles without srv_ack before abort; 0 = watchdog off
// PORTS
//  clk             in   1                 clock, rising edge
//  reset           in   1                 asynchronous, active-high
//  client_rq       in   NUM_CLIENTS       request, held until own ack
//  client_address  in   NUM_CLIENTS*AW    per-client address
//  client_wr_ni    in   NUM_CLIENTS       1 = write, 0 = read
//  client_dataW    in   NUM_CLIENTS*DW    per-client write data
//  client_ack      out  NUM_CLIENTS       one-cycle completion pulse, one-hot
//  client_dataR    out  NUM_CLIENTS*DW    read data, valid in ack cycle of that client
//  grant           out  NUM_CLIENTS       one-hot current owner, 0 when idle
//  srv_rq          out  1                 request to server
//  srv_address     out  AW                muxed address of granted client
//  srv_wr_ni       out  1                 muxed wr_ni
//  srv_dataW       out  DW                muxed write data
//  srv_ack         in   1                 server completion, one-cycle pulse
//  srv_dataR       in   DW                server read data, valid with srv_ack
//  timeout_err     out  1                 one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, watchdog counter 0, RR pointer = NUM_CLIENTS-1.
//  Reset mid-transaction aborts immediately; no ack is issued for the aborted request.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if any client_rq, select winner, register grant, srv_rq=1 next cycle (1-cycle latency).
//  Strict: minimum priority value wins; equal priorities -> lowest index wins.
//  RR: search cyclically from pointer+1; pointer <= winner index on each grant.
//  BUSY: srv_address/wr_ni/dataW combinationally muxed from granted slice; grant stable.
//   srv_ack sampled high -> srv_rq=0, client_ack[g]=1 and client_dataR slice g <= srv_dataR
//   for exactly the next cycle, go DONE.
//   TIMEOUT>0 and counter reaches TIMEOUT -> srv_rq=0, client_ack[g]=1, timeout_err=1,
//   dataR slice = 0, go DONE. srv_ack in the terminal cycle wins over timeout.
//  DONE: grant held, wait until client_rq[g]==0, then grant=0, IDLE. Min 1 cycle.
//  Requests arriving outside IDLE stay pending; evaluated in next IDLE cycle.
//  client_rq[g] dropped during BUSY: server transaction still completes, ack still issued.
//  Non-granted client_dataR slices and srv_dataR outside ack cycle: driven 0.
//  Watchdog counter: clears on entering BUSY, width $clog2(TIMEOUT+1), saturates.
// TESTING
//  Strict, default PRIO_VEC, rq[1] and rq[3] raised same cycle -> grant=4'b0010 first,
//   then 4'b1000 after client 1 drops rq.
//  RR_MODE=1, all four rq held high -> grant order 0,1,2,3,0,1 with one ack each.
//  With ram DELAY_ACK=2: client 2 writes 8'hA5 to addr 5, then reads addr 5 ->
//   client_dataR[23:16]=8'hA5 in its ack cycle; other slices 0.
//  TIMEOUT=16, server never acks -> timeout_err and client_ack pulse 16 cycles after srv_rq
//   rises, srv_rq low, dataR 0.
//  srv_ack arrives on the 16th BUSY cycle -> normal ack with data, timeout_err stays 0.
//  Assert reset during BUSY -> srv_rq, grant, client_ack 0 asynchronously; after release,
//   pending rq[0] granted first in RR mode.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// N-client rq/ack bus arbiter in front of one server. Scheduling is either strict
// priority or round robin. An optional watchdog aborts requests the server never acks.
module bus_arbiter_n #(
  parameter int                        DATA_WIDTH  = 8,
  parameter int                        ADDR_WIDTH  = 4,
  parameter int                        NUM_CLIENTS = 4,
  parameter int                        PW          = 2,
  parameter logic [NUM_CLIENTS*PW-1:0] PRIO_VEC    = 8'hE4,
  parameter int                        RR_MODE     = 0,
  parameter int                        TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            client_rq,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
  input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
  output logic [NUM_CLIENTS-1:0]            client_ack,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataR,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic                              srv_rq,
  output logic [ADDR_WIDTH-1:0]             srv_address,
  output logic                              srv_wr_ni,
  output logic [DATA_WIDTH-1:0]             srv_dataW,
  input  logic                              srv_ack,
  input  logic [DATA_WIDTH-1:0]             srv_dataR,
  output logic                              timeout_err
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [NUM_CLIENTS-1:0]            grant_q, grant_d;
  logic                              srv_rq_q, srv_rq_d;
  logic [NUM_CLIENTS-1:0]            client_ack_q, client_ack_d;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataR_q, client_dataR_d;
  logic                              timeout_err_q, timeout_err_d;
  logic [CW-1:0]                     wd_cnt_q, wd_cnt_d;
  logic [IW-1:0]                     rr_ptr_q, rr_ptr_d;

  logic                              win_found;
  logic [IW-1:0]                     win_idx;
  logic [PW-1:0]                     win_prio;
  logic [NUM_CLIENTS-1:0]            win_oh;
  logic                              owner_rq;
  logic                              wd_hit;

  // Saturating watchdog increment; the counter never wraps back to zero.
  function automatic logic [CW-1:0] wd_sat_inc(input logic [CW-1:0] c);
    if (int'(c) >= TIMEOUT) return c;
    return c + 1'b1;
  endfunction

  // Winner search over the live request vector.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '1;
    if (RR_MODE != 0) begin
      // Two passes make the search start just after the last winner and wrap.
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (!win_found && client_rq[i] && i > int'(rr_ptr_q)) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (!win_found && client_rq[i] && i <= int'(rr_ptr_q)) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
    end else begin
      // Strict less-than keeps the lowest index among equal priorities.
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (client_rq[i] && (!win_found || PRIO_VEC[i*PW +: PW] < win_prio)) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
          win_prio  = PRIO_VEC[i*PW +: PW];
        end
    end
    win_oh          = '0;
    win_oh[win_idx] = win_found;
  end

  // Server-side mux from the granted slice; grant is one-hot so OR-ing is exact.
  always_comb begin
    srv_address = '0;
    srv_wr_ni   = 1'b0;
    srv_dataW   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (grant_q[i]) begin
        srv_address = srv_address | client_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        srv_wr_ni   = srv_wr_ni | client_wr_ni[i];
        srv_dataW   = srv_dataW | client_dataW[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  assign owner_rq = |(client_rq & grant_q);
  assign wd_hit   = (TIMEOUT > 0) && (int'(wd_cnt_q) + 1 == TIMEOUT);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    srv_rq_d       = srv_rq_q;
    client_ack_d   = '0;
    client_dataR_d = '0;
    timeout_err_d  = 1'b0;
    wd_cnt_d       = wd_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = win_oh;
          srv_rq_d = 1'b1;
          wd_cnt_d = '0;
          rr_ptr_d = win_idx;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        wd_cnt_d = wd_sat_inc(wd_cnt_q);
        // A server ack in the watchdog's terminal cycle takes precedence.
        if (srv_ack) begin
          srv_rq_d     = 1'b0;
          client_ack_d = grant_q;
          for (int i = 0; i < NUM_CLIENTS; i++)
            if (grant_q[i]) client_dataR_d[i*DATA_WIDTH +: DATA_WIDTH] = srv_dataR;
          state_d = S_DONE;
        end else if (wd_hit) begin
          srv_rq_d      = 1'b0;
          client_ack_d  = grant_q;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (!owner_rq) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      srv_rq_q       <= 1'b0;
      client_ack_q   <= '0;
      client_dataR_q <= '0;
      timeout_err_q  <= 1'b0;
      wd_cnt_q       <= '0;
      rr_ptr_q       <= IW'(NUM_CLIENTS - 1);
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      srv_rq_q       <= srv_rq_d;
      client_ack_q   <= client_ack_d;
      client_dataR_q <= client_dataR_d;
      timeout_err_q  <= timeout_err_d;
      wd_cnt_q       <= wd_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign grant        = grant_q;
  assign srv_rq       = srv_rq_q;
  assign client_ack   = client_ack_q;
  assign client_dataR = client_dataR_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a strict-priority and a round-robin instance share one
// client/server stimulus; sel_rr chooses which instance the server and checks follow.
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  client_rq, client_wr_ni;
  logic [15:0] client_address;
  logic [31:0] client_dataW;
  logic        srv_ack;
  logic [7:0]  srv_dataR;

  logic [3:0]  client_ack_s, client_ack_r, grant_s, grant_r;
  logic [31:0] client_dataR_s, client_dataR_r;
  logic        srv_rq_s, srv_rq_r, srv_wr_ni_s, srv_wr_ni_r, timeout_err_s, timeout_err_r;
  logic [3:0]  srv_address_s, srv_address_r;
  logic [7:0]  srv_dataW_s, srv_dataW_r;

  bit sel_rr;
  logic [3:0]  ack, gnt, s_addr;
  logic [31:0] dataR;
  logic        s_rq, s_wr, terr;
  logic [7:0]  s_dw;
  assign ack    = sel_rr ? client_ack_r   : client_ack_s;
  assign gnt    = sel_rr ? grant_r        : grant_s;
  assign s_addr = sel_rr ? srv_address_r  : srv_address_s;
  assign dataR  = sel_rr ? client_dataR_r : client_dataR_s;
  assign s_rq   = sel_rr ? srv_rq_r       : srv_rq_s;
  assign s_wr   = sel_rr ? srv_wr_ni_r    : srv_wr_ni_s;
  assign terr   = sel_rr ? timeout_err_r  : timeout_err_s;
  assign s_dw   = sel_rr ? srv_dataW_r    : srv_dataW_s;

  bus_arbiter_n #(.RR_MODE(0), .TIMEOUT(16)) dut_s (
    .clk(clk), .reset(reset), .client_rq(client_rq), .client_address(client_address),
    .client_wr_ni(client_wr_ni), .client_dataW(client_dataW), .client_ack(client_ack_s),
    .client_dataR(client_dataR_s), .grant(grant_s), .srv_rq(srv_rq_s),
    .srv_address(srv_address_s), .srv_wr_ni(srv_wr_ni_s), .srv_dataW(srv_dataW_s),
    .srv_ack(srv_ack), .srv_dataR(srv_dataR), .timeout_err(timeout_err_s));

  bus_arbiter_n #(.RR_MODE(1), .TIMEOUT(16)) dut_r (
    .clk(clk), .reset(reset), .client_rq(client_rq), .client_address(client_address),
    .client_wr_ni(client_wr_ni), .client_dataW(client_dataW), .client_ack(client_ack_r),
    .client_dataR(client_dataR_r), .grant(grant_r), .srv_rq(srv_rq_r),
    .srv_address(srv_address_r), .srv_wr_ni(srv_wr_ni_r), .srv_dataW(srv_dataW_r),
    .srv_ack(srv_ack), .srv_dataR(srv_dataR), .timeout_err(timeout_err_r));

  int n_vec = 0;
  int n_err = 0;

  // Server model: acks after srv_delay cycles of srv_rq (never when srv_delay <= 0).
  int         srv_delay;
  int         srv_cnt;
  bit         srv_done;
  logic [7:0] mem [16];

  // Client priorities implied by PRIO_VEC = 8'hE4.
  int prio [4] = '{0, 1, 2, 3};

  function automatic int strict_pick(input logic [3:0] p);
    int best = -1;
    for (int i = 0; i < 4; i++)
      if (p[i] && (best < 0 || prio[i] < prio[best])) best = i;
    return best;
  endfunction

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int k = 1; k <= 4; k++)
      if (p[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!s_rq) begin
      srv_cnt = 0; srv_done = 0; srv_ack = 1'b0; srv_dataR = '0;
    end else if (srv_ack) begin
      srv_ack = 1'b0; srv_dataR = '0; srv_done = 1;
    end else if (!srv_done) begin
      srv_cnt++;
      if (srv_delay > 0 && srv_cnt == srv_delay) begin
        srv_ack = 1'b1;
        if (s_wr) begin
          mem[s_addr] = s_dw;
          srv_dataR   = 8'($urandom);
        end else begin
          srv_dataR = mem[s_addr];
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; client_rq = '0; srv_ack = 1'b0; srv_dataR = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; client_rq = '0;
    tick(); tick();
    n_vec++;
    if ({grant_s, client_ack_s, srv_rq_s, timeout_err_s} !== 10'd0) begin
      n_err++; $display("FAIL reset_ctrl_s: got %b want 0", {grant_s, client_ack_s, srv_rq_s, timeout_err_s});
    end
    n_vec++;
    if ({grant_r, client_ack_r, srv_rq_r, timeout_err_r} !== 10'd0) begin
      n_err++; $display("FAIL reset_ctrl_r: got %b want 0", {grant_r, client_ack_r, srv_rq_r, timeout_err_r});
    end
    n_vec++;
    if ({client_dataR_s, client_dataR_r} !== 64'd0) begin
      n_err++; $display("FAIL reset_dataR: got %h %h want 0", client_dataR_s, client_dataR_r);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_strict_pair();
    int n;
    sel_rr = 0; srv_delay = 2;
    do_reset();
    client_address = 16'h3010; client_wr_ni = '0;
    client_rq = 4'b1010;
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || s_rq !== 1'b1) begin
      n_err++; $display("FAIL strict_first: grant=%b srv_rq=%b want 0010/1", gnt, s_rq);
    end
    n_vec++;
    if (s_addr !== 4'h1) begin
      n_err++; $display("FAIL strict_addr1: got %h want 1", s_addr);
    end
    n = 0;
    while (ack === 4'b0000 && n < 50) begin tick(); n++; end
    n_vec++;
    if (ack !== 4'b0010) begin
      n_err++; $display("FAIL strict_ack1: ack=%b want 0010", ack);
    end
    client_rq[1] = 1'b0;
    n = 0;
    while (gnt !== 4'b1000 && n < 20) begin tick(); n++; end
    n_vec++;
    if (gnt !== 4'b1000 || s_addr !== 4'h3) begin
      n_err++; $display("FAIL strict_second: grant=%b addr=%h want 1000/3", gnt, s_addr);
    end
    n = 0;
    while (ack === 4'b0000 && n < 50) begin tick(); n++; end
    n_vec++;
    if (ack !== 4'b1000) begin
      n_err++; $display("FAIL strict_ack3: ack=%b want 1000", ack);
    end
    client_rq[3] = 1'b0;
    tick(); tick();
    n_vec++;
    if (gnt !== 4'b0000) begin
      n_err++; $display("FAIL strict_idle: grant=%b want 0000", gnt);
    end
  endtask

  task automatic test_rr_order();
    int n;
    int exp;
    sel_rr = 1; srv_delay = 1;
    do_reset();
    client_wr_ni = '0;
    client_rq = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp = k % 4;
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      n_vec++;
      if (gnt !== 4'(1 << exp)) begin
        n_err++; $display("FAIL rr_grant%0d: grant=%b want %b", k, gnt, 4'(1 << exp));
      end
      n = 0;
      while (ack === 4'b0000 && n < 20) begin tick(); n++; end
      n_vec++;
      if (ack !== 4'(1 << exp)) begin
        n_err++; $display("FAIL rr_ack%0d: ack=%b want %b", k, ack, 4'(1 << exp));
      end
      client_rq[exp] = 1'b0;
      tick();
      n_vec++;
      if (ack !== 4'b0000) begin
        n_err++; $display("FAIL rr_ack_pulse%0d: ack=%b want 0000", k, ack);
      end
      client_rq[exp] = 1'b1;
    end
    client_rq = '0;
    repeat (4) tick();
  endtask

  task automatic test_ram_rw();
    int n;
    sel_rr = 0; srv_delay = 2;
    do_reset();
    client_address[11:8] = 4'h5; client_wr_ni[2] = 1'b1; client_dataW[23:16] = 8'hA5;
    client_rq = 4'b0100;
    n = 0;
    while (ack[2] !== 1'b1 && n < 50) begin tick(); n++; end
    client_rq[2] = 1'b0;
    tick();
    client_wr_ni[2] = 1'b0;
    client_rq[2] = 1'b1;
    tick();
    n_vec++;
    if (gnt !== 4'b0100 || s_addr !== 4'h5 || s_wr !== 1'b0) begin
      n_err++; $display("FAIL ram_read_issue: grant=%b addr=%h wr=%b want 0100/5/0", gnt, s_addr, s_wr);
    end
    n = 0;
    while (ack[2] !== 1'b1 && n < 50) begin tick(); n++; end
    n_vec++;
    if (dataR[23:16] !== 8'hA5) begin
      n_err++; $display("FAIL ram_read_data: got %h want a5", dataR[23:16]);
    end
    n_vec++;
    if ((dataR & 32'hFF00FFFF) !== 32'd0) begin
      n_err++; $display("FAIL ram_other_slices: dataR=%h want 00a50000", dataR);
    end
    client_rq[2] = 1'b0;
    tick();
  endtask

  task automatic test_watchdog(input int delay, input bit expect_err);
    int n;
    sel_rr = 0; srv_delay = delay;
    do_reset();
    client_address[3:0] = 4'h5; client_wr_ni[0] = 1'b0;
    client_rq = 4'b0001;
    n = 0;
    while (s_rq !== 1'b1 && n < 10) begin tick(); n++; end
    n = 0;
    while (s_rq === 1'b1 && n < 40) begin tick(); n++; end
    n_vec++;
    if (n !== 16) begin
      n_err++; $display("FAIL wd_latency_d%0d: srv_rq high %0d cycles want 16", delay, n);
    end
    n_vec++;
    if (terr !== expect_err || ack !== 4'b0001) begin
      n_err++; $display("FAIL wd_pulse_d%0d: timeout_err=%b ack=%b want %b/0001", delay, terr, ack, expect_err);
    end
    n_vec++;
    if (dataR !== (expect_err ? 32'd0 : 32'h000000A5)) begin
      n_err++; $display("FAIL wd_data_d%0d: dataR=%h want %h", delay, dataR, expect_err ? 32'd0 : 32'h000000A5);
    end
    client_rq = '0;
    tick();
    n_vec++;
    if (terr !== 1'b0 || ack !== 4'b0000) begin
      n_err++; $display("FAIL wd_after_d%0d: timeout_err=%b ack=%b want 0/0000", delay, terr, ack);
    end
  endtask

  task automatic test_reset_busy();
    int n;
    sel_rr = 1; srv_delay = -1;
    do_reset();
    client_rq = 4'b0100;
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL rb_first: grant=%b want 0100", gnt);
    end
    client_rq = 4'b1101;
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || s_rq !== 1'b0 || ack !== 4'b0000) begin
      n_err++; $display("FAIL rb_async: grant=%b srv_rq=%b ack=%b want all 0", gnt, s_rq, ack);
    end
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || ack !== 4'b0000) begin
      n_err++; $display("FAIL rb_regrant: grant=%b ack=%b want 0001/0000", gnt, ack);
    end
    client_rq = '0;
  endtask

  task automatic test_random(input bit mode);
    logic [3:0]  prev_rq, prev_gnt, exp_ack, dropped;
    logic        prev_srq, prev_sack;
    logic [7:0]  prev_sdata;
    logic [31:0] exp_dr;
    int w, model_ptr, txns;
    sel_rr = mode; srv_delay = 2;
    do_reset();
    model_ptr = 3; txns = 0; dropped = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++)
        if (cyc < 350 && !client_rq[i] && !dropped[i] && $urandom_range(0, 2) == 0) begin
          client_rq[i] = 1'b1;
          client_address[i*4 +: 4] = 4'($urandom);
          client_wr_ni[i] = 1'($urandom);
          client_dataW[i*8 +: 8] = 8'($urandom);
        end
      if (!s_rq) srv_delay = int'($urandom_range(1, 4));
      prev_rq = client_rq; prev_gnt = gnt; prev_srq = s_rq;
      prev_sack = srv_ack; prev_sdata = srv_dataR;
      tick();
      dropped = '0;
      if (prev_gnt == 4'b0000) begin
        w = (prev_rq == 4'b0000) ? -1 : (mode ? rr_pick(prev_rq, model_ptr) : strict_pick(prev_rq));
        n_vec++;
        if (gnt !== ((w < 0) ? 4'b0000 : 4'(1 << w))) begin
          n_err++; $display("FAIL rand%0d_grant c%0d: grant=%b rq=%b want winner %0d", mode, cyc, gnt, prev_rq, w);
        end
        if (w >= 0) begin
          n_vec++;
          if (s_addr !== client_address[w*4 +: 4] || s_dw !== client_dataW[w*8 +: 8]) begin
            n_err++; $display("FAIL rand%0d_mux c%0d: addr=%h data=%h want %h/%h", mode, cyc, s_addr, s_dw,
                              client_address[w*4 +: 4], client_dataW[w*8 +: 8]);
          end
          model_ptr = w;
        end
      end
      exp_ack = (prev_sack && prev_srq) ? prev_gnt : 4'b0000;
      n_vec++;
      if (ack !== exp_ack || terr !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_ack c%0d: ack=%b err=%b want %b/0", mode, cyc, ack, terr, exp_ack);
      end
      if (exp_ack != 4'b0000) begin
        exp_dr = '0;
        for (int i = 0; i < 4; i++) if (exp_ack[i]) exp_dr[i*8 +: 8] = prev_sdata;
        n_vec++;
        if (dataR !== exp_dr) begin
          n_err++; $display("FAIL rand%0d_data c%0d: dataR=%h want %h", mode, cyc, dataR, exp_dr);
        end
        txns++;
      end
      dropped = ack & client_rq;
      client_rq = client_rq & ~ack;
    end
    n_vec++;
    if (txns < 20) begin
      n_err++; $display("FAIL rand%0d_throughput: %0d transactions want >= 20", mode, txns);
    end
    client_rq = '0;
  endtask

  initial begin
    sel_rr = 0; reset = 1'b1; client_rq = '0; client_wr_ni = '0;
    client_address = '0; client_dataW = '0; srv_ack = 1'b0; srv_dataR = '0;
    srv_delay = 2; srv_cnt = 0; srv_done = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_strict_pair();
    test_rr_order();
    test_ram_rw();
    test_watchdog(-1, 1'b1);
    test_watchdog(16, 1'b0);
    test_reset_busy();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
